// File: rtl/ps2_pkg.sv
// Shared constants, byte type and parity helper for the PS/2 receive path.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_START_IDX  = 0;
  localparam int unsigned PS2_PARITY_IDX = 9;
  localparam int unsigned PS2_STOP_IDX   = 10;
  localparam int unsigned PS2_CNT_W      = $clog2(PS2_FRAME_BITS);

  typedef logic [7:0] ps2_byte_t;

  // Odd parity holds when the data bits and the parity bit XOR to 1.
  function automatic logic ps2_parity_ok(input ps2_byte_t data_bits, input logic parity_bit);
    return (^data_bits) ^ parity_bit;
  endfunction

endpackage

// File: rtl/ps2_rx_frontend_fifo.sv
// Scan-code byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  ps2_byte_t push_data,
  input  logic      pop,
  output ps2_byte_t head,
  output logic      empty,
  output logic      full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  ps2_byte_t     mem [FIFO_DEPTH];
  logic          do_pop;
  logic          do_push;

  // A pop on empty is ignored; a push on full is taken only alongside a real pop.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Storage and pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: sync, frame check, timeout abort, byte FIFO.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]                clk_sync;
  logic [1:0]                dat_sync;
  logic                      clk_prev;
  logic                      nd_prev;
  logic [PS2_FRAME_BITS-2:0] shreg;
  logic [PS2_CNT_W-1:0]      bit_cnt;
  logic [IDLE_W-1:0]         idle_cnt;

  logic                      fall;
  logic                      last_bit;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                      frame_ok;
  logic                      byte_valid;
  logic                      pop_req;
  logic                      pop_eff;
  logic                      fifo_empty;
  logic                      fifo_full;
  ps2_byte_t                 fifo_head;

  // Edge detection, frame assembly and validity of the frame ending this cycle.
  always_comb begin
    fall       = clk_prev && !clk_sync[1];
    last_bit   = fall && (bit_cnt == PS2_CNT_W'(PS2_STOP_IDX));
    frame      = {dat_sync[1], shreg};
    frame_ok   = !frame[PS2_START_IDX] && frame[PS2_STOP_IDX] &&
                 ps2_parity_ok(frame[8:1], frame[PS2_PARITY_IDX]);
    byte_valid = last_bit && frame_ok;
    pop_req    = !nd_prev && nextdata_n;
    pop_eff    = pop_req && !fifo_empty;
  end

  // Synchronizers, shifter, bit counter, idle timeout, error pulse and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_prev  <= 1'b1;
      nd_prev   <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
      nd_prev   <= nextdata_n;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (last_bit) begin
          bit_cnt   <= '0;
          frame_err <= !frame_ok;
        end else begin
          shreg   <= {dat_sync[1], shreg[PS2_FRAME_BITS-2:1]};
          bit_cnt <= bit_cnt + PS2_CNT_W'(1);
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
      if (pop_eff) begin
        overflow <= 1'b0;
      end else if (byte_valid && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  ps2_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (byte_valid),
    .push_data(frame[8:1]),
    .pop      (pop_req),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign data  = fifo_head;
  assign ready = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Scoreboard bench for ps2_rx_frontend: 5 MHz system clock, 10 us PS/2 bit period.
`timescale 1ns/1ps
module tb_ps2_rx_frontend;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  logic [7:0] exp_q[$];

  ps2_rx_frontend #(
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #100 clock = ~clock;

  // Count cycles with frame_err high; one clean pulse adds exactly 1.
  always @(negedge clock) begin
    if (frame_err === 1'b1) err_pulses++;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive nbits of a frame; the scoreboard is fed only for complete valid frames.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (~^b) ^ flip_par;
    f[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #5000;
      ps2_clk = 1'b0;
      #5000;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(10);
    if (nbits == 11 && !flip_par && !bad_stop && exp_q.size() < 8) exp_q.push_back(b);
  endtask

  // Hold nextdata_n low, record the byte seen and whether it stayed put, then release.
  task automatic pulse_read(input int low_cycles, output logic [7:0] held, output bit stable);
    nextdata_n = 1'b0;
    held = data;
    stable = 1'b1;
    for (int i = 0; i < low_cycles; i++) begin
      @(posedge clock);
      #1;
      if (data !== held) stable = 1'b0;
    end
    nextdata_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_single_byte();
    int e0;
    logic [7:0] held;
    bit stable;
    e0 = err_pulses;
    send_frame(8'h1C, 0, 0, 11);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready); end
    checks++; if (data !== exp_q[0]) begin failures++; $display("FAIL single_data got=%h exp=%h", data, exp_q[0]); end
    checks++; if (err_pulses != e0) begin failures++; $display("FAIL single_no_err got=%0d exp=%0d", err_pulses, e0); end
    pulse_read(2, held, stable);
    checks++; if (held !== exp_q[0]) begin failures++; $display("FAIL single_read got=%h exp=%h", held, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] held;
    bit stable;
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 11);
    pulse_read(2, held, stable);
    checks++; if (held !== exp_q[0] || !stable) begin failures++; $display("FAIL b2b_first got=%h stable=%b exp=%h", held, stable, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (data !== exp_q[0] || ready !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h ready=%b exp=%h", data, ready, exp_q[0]); end
    pulse_read(5, held, stable);
    checks++; if (held !== exp_q[0] || !stable) begin failures++; $display("FAIL b2b_long_low got=%h stable=%b exp=%h", held, stable, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", ready); end
    pulse_read(2, held, stable);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL empty_pop_ready got=%b exp=0", ready); end
    send_frame(8'h55, 0, 0, 11);
    checks++; if (data !== exp_q[0] || ready !== 1'b1) begin failures++; $display("FAIL empty_pop_ptrs got=%h ready=%b exp=%h", data, ready, exp_q[0]); end
    pulse_read(1, held, stable);
    void'(exp_q.pop_front());
  endtask

  task automatic test_bad_frames();
    int e0;
    e0 = err_pulses;
    send_frame(8'h1C, 1, 0, 11);
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL parity_err_pulses got=%0d exp=1", err_pulses - e0); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL parity_ready got=%b exp=0", ready); end
    e0 = err_pulses;
    send_frame(8'h1C, 0, 1, 11);
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL stop_err_pulses got=%0d exp=1", err_pulses - e0); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL stop_ready got=%b exp=0", ready); end
  endtask

  task automatic test_overflow();
    logic [7:0] held;
    bit stable;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 0, 0, 11);
      if (i == 8) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%b exp=0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    for (int i = 0; i < 8; i++) begin
      pulse_read(2, held, stable);
      checks++; if (held !== exp_q[0]) begin failures++; $display("FAIL ovf_read%0d got=%h exp=%h", i, held, exp_q[0]); end
      void'(exp_q.pop_front());
      if (i == 0) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
      end
    end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", ready); end
  endtask

  task automatic test_timeout();
    int e0;
    logic [7:0] held;
    bit stable;
    e0 = err_pulses;
    send_frame(8'h2A, 0, 0, 4);
    cycles(150);
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", err_pulses - e0); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL timeout_ready got=%b exp=0", ready); end
    e0 = err_pulses;
    send_frame(8'h2A, 0, 0, 11);
    checks++; if (data !== exp_q[0] || ready !== 1'b1) begin failures++; $display("FAIL after_timeout got=%h ready=%b exp=%h", data, ready, exp_q[0]); end
    checks++; if (err_pulses != e0) begin failures++; $display("FAIL after_timeout_err got=%0d exp=%0d", err_pulses, e0); end
    pulse_read(1, held, stable);
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_midframe();
    int e0;
    logic [7:0] held;
    bit stable;
    send_frame(8'hA1, 0, 0, 11);
    send_frame(8'hA2, 0, 0, 11);
    send_frame(8'hA3, 0, 0, 11);
    checks++; if (ready !== 1'b1 || data !== exp_q[0]) begin failures++; $display("FAIL pre_reset got=%h ready=%b exp=%h", data, ready, exp_q[0]); end
    send_frame(8'h77, 0, 0, 6);
    @(posedge clock); #1;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    exp_q.delete();
    cycles(1);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%b exp=0", ready); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL midreset_data got=%h exp=00", data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midreset_overflow got=%b exp=0", overflow); end
    e0 = err_pulses;
    send_frame(8'h33, 0, 0, 11);
    checks++; if (data !== exp_q[0] || ready !== 1'b1) begin failures++; $display("FAIL post_reset got=%h ready=%b exp=%h", data, ready, exp_q[0]); end
    checks++; if (err_pulses != e0) begin failures++; $display("FAIL post_reset_err got=%0d exp=%0d", err_pulses, e0); end
    pulse_read(1, held, stable);
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_bad_frames();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
- Receives PS/2 device-to-host serial frames (ps2_clk/ps2_data from pads) and checks each 11-bit frame.
- Buffers accepted scan-code bytes in a small FIFO.
- Presents the FIFO head plus a not-empty flag to the APB peripheral wrapper directly downstream.
- Pop is driven by the wrapper's active-low read strobe, `nextdata_n`.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000, clock cycles with no ps2_clk falling edge mid-frame before the partial frame is aborted.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- ps2_clk  input  1  asynchronous PS/2 clock from pad.
- ps2_data  input  1  asynchronous PS/2 data from pad.
- nextdata_n  input  1  active-low read strobe from the bus wrapper; may stay low several cycles.
- data  output  8  FIFO head byte.
- ready  output  1  FIFO not empty.
- overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: bad start/stop/parity, or timeout abort.

Behaviour:
- Clocking and reset
  - All state is on posedge clock. Reset is synchronous, active-high.
  - Reset values: ready=0, overflow=0, frame_err=0, data=8'h00.
  - FIFO storage resets to 0. Pointers, bit counter and timeout counter clear. Sync flops reset to 1.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Input sync and edge detect
  - ps2_clk and ps2_data each pass through 2-flop synchronizers.
  - A falling edge is detected in the cycle where the previous synced ps2_clk is 1 and the current synced value is 0.
  - On that cycle the synced ps2_data is shifted in, LSB first.
- Frame format (11 bits)
  - Bit 0 is start (must be 0).
  - Bits 1–8 are data, LSB first.
  - Bit 9 is odd parity: XOR of data bits and parity bit must be 1.
  - Bit 10 is stop (must be 1).
- Bit counter
  - Counts 0..10. On the edge carrying bit 10 the frame is evaluated and the counter returns to 0.
- Frame outcomes
  - Valid frame, FIFO not full: byte is pushed on that clock edge; ready is high from the next cycle.
  - Valid frame, FIFO full, no pop this cycle: byte is dropped and overflow is set.
  - Valid frame, FIFO full, pop this cycle: push is accepted; count is unchanged.
  - Invalid frame: discarded; frame_err=1 for exactly one cycle; FIFO untouched.
- Timeout
  - While the bit counter is ≠0, an idle counter increments every cycle without a falling edge and clears on each edge.
  - When it reaches TIMEOUT_CYCLES, the bit counter resets to 0, frame_err pulses one cycle, and the idle counter clears.
  - The idle counter does not run while the bit counter is 0.
- Pop rule
  - A pop occurs on the cycle nextdata_n rises (previous 0, current 1) and ready=1.
  - data is therefore stable for the whole low period of nextdata_n, however many cycles that lasts.
  - A rising edge of nextdata_n while empty is ignored; pointers are unchanged.
- FIFO
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Empty when the pointers are equal. Full when the index bits are equal and the MSBs differ.
  - Simultaneous push and pop when not full and not empty: both take effect; occupancy is unchanged.
  - Simultaneous push and pop when empty: push only; the pop is ignored.
- Outputs
  - data = mem[rd_index], combinational from registered state; shows a stale value when ready=0.
  - overflow is sticky; it clears only on a pop or on reset.

Decomposition:
- Package ps2_pkg:
  - PS2_FRAME_BITS=11, PS2_START_IDX=0, PS2_PARITY_IDX=9, PS2_STOP_IDX=10.
  - Typedef ps2_byte_t (8-bit).
  - Function for the odd-parity check.
- One sub-module, ps2_byte_fifo, parameterized by FIFO_DEPTH.
  - Ports: push, push_data, pop, head, empty, full.
- Synchronizers, shifter, bit counter and timeout stay in the top level.

Test Plan:
- Reset, then send 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at a 10 µs PS/2 period → ready=1, data=8'h1C, frame_err never pulses.
- Send 0xF0 then 0x1C; pulse nextdata_n low for 2 cycles, then high → data=8'hF0 throughout the low period; after the rise data=8'h1C and ready=1. A second pulse → ready=0.
- Send 0x1C with the parity bit flipped → exactly one frame_err pulse; ready stays 0. Repeat with stop=0 → same response.
- Send 9 valid bytes 0x01..0x09 with no reads (FIFO_DEPTH=8) → overflow=1 after the 9th. Reads return 0x01..0x08. overflow clears on the first pop.
- Set TIMEOUT_CYCLES=100; send 4 bits, then idle 150 cycles → frame_err pulses once. A following full 0x2A frame → data=8'h2A with no error.
- Assert reset after 6 bits of a frame and with 3 bytes queued → ready=0, data=8'h00, overflow=0. The next complete 0x33 frame is received correctly.
